// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   Sequences one CPU instruction at a time onto a single-ported external
//   SRAM. Each instruction is an instruction fetch, an optional data access
//   (load or store) and a single commit cycle. Every memory access lasts
//   WAIT_STATES+1 cycles.
//
// Parameters
//   WAIT_STATES  extra cycles per memory access (0..7)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cpu_pc                   instruction fetch address
//   cpu_addr, cpu_wdata      data access address / store data
//   cpu_rw, cpu_dreq         data direction (1 = write) / data access needed
//   dbg_halt                 stop request, honoured between instructions
//   cpu_ir, cpu_rdata        latched instruction word / load data
//   cpu_halt                 core stall, low only in the commit cycle
//   mem_addr, mem_wdata      SRAM address / write data
//   mem_rdata                SRAM read data
//   mem_oe, mem_we           SRAM read strobe / write strobe
module mem_bus_ctrl #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_pc,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_rw,
  input  logic        cpu_dreq,
  input  logic        dbg_halt,
  output logic [15:0] cpu_ir,
  output logic [15:0] cpu_rdata,
  output logic        cpu_halt,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_oe,
  output logic        mem_we
);

  localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    EXEC
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nxt;
  logic        last;
  logic        dreq_q;
  logic        rw_q;
  logic        dreq_eff;
  logic        rw_eff;
  logic        ir_load;
  logic        rd_load;

  // The data-access decision is taken from the freshly latched instruction,
  // i.e. sampled on the first DATA cycle and held for the rest of the access
  // so the strobes cannot change direction mid-access.
  always_comb begin
    last     = (cnt == LAST_CNT);
    dreq_eff = (cnt == '0) ? cpu_dreq : dreq_q;
    rw_eff   = (cnt == '0) ? cpu_rw   : rw_q;
  end

  always_comb begin
    state_nxt = state;
    cpu_halt  = 1'b1;
    mem_oe    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ir_load   = 1'b0;
    rd_load   = 1'b0;

    case (state)
      IDLE: begin
        if (!dbg_halt) state_nxt = FETCH;
      end

      FETCH: begin
        mem_addr = cpu_pc;
        mem_oe   = 1'b1;
        if (last) begin
          ir_load   = 1'b1;
          state_nxt = DATA;
        end
      end

      DATA: begin
        mem_addr = cpu_addr;
        if (!dreq_eff) begin
          // No data access: a single empty DATA cycle.
          state_nxt = EXEC;
        end else begin
          if (rw_eff) begin
            mem_we    = 1'b1;
            mem_wdata = cpu_wdata;
          end else begin
            mem_oe  = 1'b1;
            rd_load = last;
          end
          if (last) state_nxt = EXEC;
        end
      end

      EXEC: begin
        cpu_halt  = 1'b0;
        state_nxt = dbg_halt ? IDLE : FETCH;
      end

      default: state_nxt = IDLE;
    endcase

    // Strobes are killed immediately on reset, even mid-access.
    if (rst) begin
      mem_oe   = 1'b0;
      mem_we   = 1'b0;
      cpu_halt = 1'b1;
    end

    // Counter only runs inside an access and restarts on every state change.
    if ((state_nxt != state) || !((state == FETCH) || (state == DATA))) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cpu_ir    <= '0;
      cpu_rdata <= '0;
      dreq_q    <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ir_load) cpu_ir    <= mem_rdata;
      if (rd_load) cpu_rdata <= mem_rdata;
      if ((state == DATA) && (cnt == '0)) begin
        dreq_q <= cpu_dreq;
        rw_q   <= cpu_rw;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl
//   Two lanes, each with its own mem_bus_ctrl (WAIT_STATES = 1 and 0), its
//   own SRAM model and a per-cycle expectation queue built from the
//   instruction timing rules. A compare process pops one expected cycle per
//   falling edge and checks every output against it.
module tb_mem_bus_ctrl;

  typedef struct packed {
    logic        oe;
    logic        we;
    logic        halt;
    logic        ca;
    logic        cw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] ir;
    logic [15:0] rd;
  } rec_t;

  logic clk;
  int   checks;
  int   failures;
  bit   done [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(int lane, string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL L%0d %s actual=%h required=%h t=%0t", lane, name, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int W = 1 - g;

    logic        rst;
    logic        dbg_halt;
    logic        cpu_rw;
    logic        cpu_dreq;
    logic        cpu_halt;
    logic        mem_oe;
    logic        mem_we;
    logic [15:0] cpu_pc;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_ir;
    logic [15:0] cpu_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] mem [0:65535];
    rec_t        q [$];
    logic [15:0] ir_m;
    logic [15:0] rd_m;

    mem_bus_ctrl #(.WAIT_STATES(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_pc    (cpu_pc),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rw    (cpu_rw),
      .cpu_dreq  (cpu_dreq),
      .dbg_halt  (dbg_halt),
      .cpu_ir    (cpu_ir),
      .cpu_rdata (cpu_rdata),
      .cpu_halt  (cpu_halt),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_oe    (mem_oe),
      .mem_we    (mem_we)
    );

    assign mem_rdata = mem[mem_addr];

    // SRAM: random contents plus the fixed words used by the directed cases.
    initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[16'h000F] = 16'h1234;
      mem[16'h0200] = 16'hBEEF;
      forever begin
        @(negedge clk);
        if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
      end
    end

    // Compare process
    initial begin
      rec_t r;
      forever begin
        @(negedge clk);
        if (q.size() != 0) begin
          r = q.pop_front();
          chk(g, "cpu_halt", 16'(cpu_halt), 16'(r.halt));
          chk(g, "mem_oe", 16'(mem_oe), 16'(r.oe));
          chk(g, "mem_we", 16'(mem_we), 16'(r.we));
          chk(g, "oe_we_excl", 16'(mem_oe & mem_we), 16'h0000);
          if (r.ca) chk(g, "mem_addr", mem_addr, r.addr);
          if (r.cw) chk(g, "mem_wdata", mem_wdata, r.wdata);
          chk(g, "cpu_ir", cpu_ir, r.ir);
          chk(g, "cpu_rdata", cpu_rdata, r.rd);
        end
      end
    end

    function automatic void push(logic oe, logic we, logic halt, logic ca, logic cw,
                                 logic [15:0] addr, logic [15:0] wdata);
      rec_t r;
      r.oe = oe; r.we = we; r.halt = halt; r.ca = ca; r.cw = cw;
      r.addr = addr; r.wdata = wdata; r.ir = ir_m; r.rd = rd_m;
      q.push_back(r);
    endfunction

    // Stay parked with dbg_halt high for m cycles.
    task automatic idle(int m);
      dbg_halt  = 1'b1;
      cpu_pc    = 16'($urandom);
      cpu_addr  = 16'($urandom);
      cpu_wdata = 16'($urandom);
      for (int i = 0; i < m; i++) push(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
      for (int i = 0; i < m; i++) begin
        @(negedge clk);
        #1;
      end
    endtask

    // One instruction: fetch, data (or one empty cycle), commit.
    // halt_at >= 0 raises dbg_halt on that cycle of the instruction.
    task automatic instr(input logic [15:0] pc, input logic [15:0] a, input logic [15:0] wd,
                         input logic rw, input logic dq, input int halt_at,
                         input logic [15:0] ir_exp, input logic [15:0] rd_exp);
      int nf;
      int nd;
      int n;
      int seen;
      nf = W + 1;
      nd = dq ? W + 1 : 1;
      n  = nf + nd + 1;
      seen = -1;
      cpu_pc = pc; cpu_addr = a; cpu_wdata = wd; cpu_rw = rw; cpu_dreq = dq;
      dbg_halt = 1'b0;
      for (int i = 0; i < nf; i++) push(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pc, 16'h0000);
      ir_m = ir_exp;
      for (int i = 0; i < nd; i++) begin
        if (dq) push(!rw, rw, 1'b1, 1'b1, rw, a, rw ? wd : 16'h0000);
        else    push(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, a, 16'h0000);
      end
      if (dq && !rw) rd_m = rd_exp;
      push(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        #1;
        if ((cpu_halt === 1'b0) && (seen < 0)) seen = i;
        if (i == halt_at) dbg_halt = 1'b1;
      end
      chk(g, "instr_cycles", 16'(seen + 1), dq ? 16'(2 * (W + 1) + 1) : 16'((W + 1) + 2));
    endtask

    // Store whose final DATA cycle is hit by reset.
    task automatic rst_store(input logic [15:0] pc, input logic [15:0] a, input logic [15:0] wd);
      cpu_pc = pc; cpu_addr = a; cpu_wdata = wd; cpu_rw = 1'b1; cpu_dreq = 1'b1;
      dbg_halt = 1'b0;
      for (int i = 0; i < W + 1; i++) push(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pc, 16'h0000);
      ir_m = mem[pc];
      for (int i = 0; i < W; i++) push(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, a, wd);
      push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, 16'h0000);
      ir_m = 16'h0000;
      rd_m = 16'h0000;
      push(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
      for (int i = 0; i < 2 * W + 1; i++) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
    endtask

    // Driver
    initial begin
      logic [15:0] pc;
      logic [15:0] a;
      logic [15:0] wd;
      logic        rw;
      logic        dq;
      int          n;
      int          h;
      rst = 1'b1; dbg_halt = 1'b1;
      cpu_pc = '0; cpu_addr = '0; cpu_wdata = '0; cpu_rw = 1'b0; cpu_dreq = 1'b0;
      ir_m = 16'h0000;
      rd_m = 16'h0000;
      for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      idle(2);

      // Fetch-only instruction
      instr(16'h000F, 16'h0040, 16'h0000, 1'b0, 1'b0, -1, 16'h1234, 16'h0000);
      chk(g, "ir_pin", cpu_ir, 16'h1234);
      // Load
      instr(16'h0010, 16'h0200, 16'h0000, 1'b0, 1'b1, -1, mem[16'h0010], 16'hBEEF);
      chk(g, "rdata_pin", cpu_rdata, 16'hBEEF);
      // Store
      instr(16'h0011, 16'h0300, 16'hA5A5, 1'b1, 1'b1, -1, mem[16'h0011], 16'h0000);
      chk(g, "store_pin", mem[16'h0300], 16'hA5A5);
      // Halt request during fetch: completes, then parks
      instr(16'h0012, 16'h0201, 16'h0000, 1'b0, 1'b1, 0, mem[16'h0012], mem[16'h0201]);
      idle(3);
      chk(g, "parked_halt", 16'(cpu_halt), 16'h0001);
      // Reset hitting a store, then immediate restart
      rst_store(16'h0020, 16'h0301, 16'h5A5A);
      chk(g, "rst_ir_pin", cpu_ir, 16'h0000);

      for (int k = 0; k < 80; k++) begin
        pc = 16'($urandom);
        a  = 16'($urandom);
        wd = 16'($urandom);
        rw = 1'($urandom);
        dq = 1'($urandom);
        if ($urandom_range(0, 19) == 0) begin
          rst_store(pc, a, wd);
        end else begin
          n = dq ? 2 * W + 3 : W + 3;
          h = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
          instr(pc, a, wd, rw, dq, h, mem[pc], mem[a]);
          if ((h >= 0) || ($urandom_range(0, 7) == 0)) idle(int'($urandom_range(1, 3)));
        end
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    wait (done[0] && done[1]);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
